// File: rtl/step_tick_gen.sv
// Programmable tick source for the step counter: free-running, counted burst, or manual
// single-step ticks, all as single-cycle clk-synchronous pulses.
module step_tick_gen #(
  parameter int unsigned CNT_W = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             start,
  input  logic             step_req,
  input  logic [CNT_W-1:0] period,
  input  logic [3:0]       burst_len,
  output logic             tick,
  output logic             done,
  output logic             busy,
  output logic [3:0]       remaining
);

  typedef enum logic [1:0] {StIdle, StRun, StBurst} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       rem_q, rem_d;
  logic             req_q;
  logic             tick_q, tick_d;
  logic             done_q, done_d;
  logic             busy_q;

  logic             per_zero;
  logic [CNT_W-1:0] per_m1;
  logic             wrap;
  logic             man_edge;

  assign per_zero = (period == '0);
  // period-1 is only meaningful for a non-zero period; force 0 otherwise.
  assign per_m1   = per_zero ? '0 : (period - CNT_W'(1));
  // >= so that a period shrunk mid-interval wraps at once.
  assign wrap     = !per_zero && (cnt_q >= per_m1);
  assign man_edge = step_req & ~req_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    tick_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (start && (burst_len != 4'd0) && !per_zero) begin
          state_d = StBurst;
          rem_d   = burst_len;
        end else if (enable && !per_zero) begin
          state_d = StRun;
        end else if (man_edge) begin
          tick_d = 1'b1;
        end
      end
      StRun: begin
        if (!enable || per_zero) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (wrap) begin
          cnt_d  = '0;
          tick_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StBurst: begin
        if (per_zero) begin
          state_d = StIdle;
          rem_d   = 4'd0;
          cnt_d   = '0;
        end else if (wrap) begin
          cnt_d  = '0;
          tick_d = 1'b1;
          rem_d  = rem_q - 4'd1;
          if (rem_q == 4'd1) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        rem_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rem_q   <= 4'd0;
      req_q   <= 1'b0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      req_q   <= step_req;
      tick_q  <= tick_d;
      done_q  <= done_d;
      busy_q  <= (state_d != StIdle);
    end
  end

  assign tick      = tick_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign remaining = rem_q;

endmodule

// File: tb/tb_step_tick_gen.sv
// Self-checking bench for step_tick_gen: directed scenarios with literal timing checks, then
// randomized stimulus compared every cycle against an interval-based behavioural model.
module tb_step_tick_gen;

  localparam int unsigned CNT_W = 27;

  logic             clk;
  logic             rst;
  logic             enable;
  logic             start;
  logic             step_req;
  logic [CNT_W-1:0] period;
  logic [3:0]       burst_len;
  logic             tick;
  logic             done;
  logic             busy;
  logic [3:0]       remaining;

  step_tick_gen #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .start     (start),
    .step_req  (step_req),
    .period    (period),
    .burst_len (burst_len),
    .tick      (tick),
    .done      (done),
    .busy      (busy),
    .remaining (remaining)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit chk_en = 0;
  int tick_cyc[$];
  int done_cyc[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: mode 0 idle / 1 free-run / 2 burst; elapsed = clk edges since interval start.
  typedef struct {
    int mode;
    int elapsed;
    int left;
    bit prev_req;
    bit tick;
    bit done;
  } mdl_t;

  mdl_t m = '{default: 0};

  function automatic mdl_t model_next(mdl_t c, bit en, bit st, bit req, int per, int bl);
    mdl_t n;
    bit   rise;
    n          = c;
    n.tick     = 0;
    n.done     = 0;
    n.prev_req = req;
    rise       = req && !c.prev_req;
    if (c.mode == 0) begin
      n.elapsed = 0;
      if (st && bl != 0 && per != 0) begin
        n.mode = 2;
        n.left = bl;
      end else if (en && per != 0) begin
        n.mode = 1;
      end else if (rise) begin
        n.tick = 1;
      end
    end else if ((c.mode == 1 && (!en || per == 0)) || (c.mode == 2 && per == 0)) begin
      n.mode    = 0;
      n.elapsed = 0;
      n.left    = 0;
    end else if (c.elapsed + 1 >= per) begin
      n.elapsed = 0;
      n.tick    = 1;
      if (c.mode == 2) begin
        n.left = c.left - 1;
        if (n.left == 0) begin
          n.done = 1;
          n.mode = 0;
        end
      end
    end else begin
      n.elapsed = c.elapsed + 1;
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= '{default: 0};
    else m <= model_next(m, enable, start, step_req, int'(period), int'(burst_len));
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("tick", int'(tick), int'(m.tick));
      chk("done", int'(done), int'(m.done));
      chk("busy", int'(busy), (m.mode != 0) ? 1 : 0);
      chk("remaining", int'(remaining), (m.mode == 2) ? m.left : 0);
      if (tick) tick_cyc.push_back(cyc);
      if (done) done_cyc.push_back(cyc);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int e0;
  int e1;
  int pers[6] = '{0, 1, 2, 3, 5, 7};

  initial begin
    rst       = 1'b0;
    enable    = 1'b1;
    start     = 1'b0;
    step_req  = 1'b0;
    period    = CNT_W'(4);
    burst_len = 4'd0;
    #2 rst = 1'b1;
    #1 chk_en = 1;

    // Reset held with enable=1, period=4; then free-run.
    step(3);
    chk("rst_tick", int'(tick), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_rem", int'(remaining), 0);
    chk("rst_done", int'(done), 0);
    rst = 1'b0;
    tick_cyc.delete();
    step(1);
    e0 = cyc;
    chk("run_busy_entry", int'(busy), 1);
    step(10);
    chk("run_nticks", tick_cyc.size(), 2);
    chk("run_first", tick_cyc[0] - e0, 4);
    chk("run_space", tick_cyc[1] - tick_cyc[0], 4);
    chk("run_busy", int'(busy), 1);
    enable = 1'b0;
    step(3);

    // Burst of 3 at period 2.
    period    = CNT_W'(2);
    burst_len = 4'd3;
    start     = 1'b1;
    tick_cyc.delete();
    done_cyc.delete();
    step(1);
    e0    = cyc;
    start = 1'b0;
    chk("burst_rem3", int'(remaining), 3);
    step(2);
    chk("burst_rem2", int'(remaining), 2);
    step(8);
    chk("burst_nticks", tick_cyc.size(), 3);
    chk("burst_t1", tick_cyc[0] - e0, 2);
    chk("burst_t2", tick_cyc[1] - e0, 4);
    chk("burst_t3", tick_cyc[2] - e0, 6);
    chk("burst_ndone", done_cyc.size(), 1);
    chk("burst_done_at", done_cyc[0] - e0, 6);
    chk("burst_busy_after", int'(busy), 0);

    // Period 0 freezes; a held manual request gives one tick.
    period    = '0;
    enable    = 1'b1;
    start     = 1'b1;
    burst_len = 4'd3;
    tick_cyc.delete();
    step(1);
    start = 1'b0;
    step(4);
    chk("frozen_nticks", tick_cyc.size(), 0);
    chk("frozen_busy", int'(busy), 0);
    step_req = 1'b1;
    step(1);
    e0 = cyc;
    step(10);
    chk("manual_nticks", tick_cyc.size(), 1);
    chk("manual_lat", tick_cyc[0] - e0, 0);
    step_req = 1'b0;
    enable   = 1'b0;
    step(2);

    // Drop enable at cnt=5 of an 8-cycle interval, then re-enter.
    period = CNT_W'(8);
    enable = 1'b1;
    tick_cyc.delete();
    step(1);
    step(5);
    enable = 1'b0;
    step(3);
    chk("drop_nticks", tick_cyc.size(), 0);
    chk("drop_busy", int'(busy), 0);
    enable = 1'b1;
    step(1);
    e1 = cyc;
    step(10);
    chk("reenter_first", tick_cyc[0] - e1, 8);
    enable = 1'b0;
    step(2);

    // Shrink period 10 -> 3 at cnt=6.
    period = CNT_W'(10);
    enable = 1'b1;
    tick_cyc.delete();
    step(1);
    e0 = cyc;
    step(6);
    period = CNT_W'(3);
    step(8);
    chk("shrink_nticks", tick_cyc.size(), 3);
    chk("shrink_t1", tick_cyc[0] - e0, 7);
    chk("shrink_t2", tick_cyc[1] - e0, 10);
    chk("shrink_t3", tick_cyc[2] - e0, 13);
    enable = 1'b0;
    step(2);

    // Reset during a 5-tick burst at period 4, right after the second tick.
    period    = CNT_W'(4);
    burst_len = 4'd5;
    start     = 1'b1;
    tick_cyc.delete();
    step(1);
    e0    = cyc;
    start = 1'b0;
    step(8);
    chk("abort_pre_nticks", tick_cyc.size(), 1);
    chk("abort_pre_tick", int'(tick), 1);
    chk("abort_pre_rem", int'(remaining), 3);
    rst = 1'b1;
    #1;
    chk("abort_tick", int'(tick), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_rem", int'(remaining), 0);
    step(2);
    rst = 1'b0;
    tick_cyc.delete();
    step(30);
    chk("abort_after_nticks", tick_cyc.size(), 0);

    // Randomized stimulus, checked every cycle by the compare process.
    for (int i = 0; i < 4000; i++) begin
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 499) == 0) rst = 1'b1;
      if ($urandom_range(0, 19) == 0) period = CNT_W'(pers[$urandom_range(0, 5)]);
      if ($urandom_range(0, 14) == 0) enable = ~enable;
      if ($urandom_range(0, 3) == 0) step_req = ~step_req;
      start     = ($urandom_range(0, 9) == 0);
      burst_len = 4'($urandom_range(0, 15));
      step(1);
    end
    rst = 1'b0;
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
